// File: rtl/multi_chan_data_transfer.sv
// Round-robin packetiser: pulls one event at a time from NUM_CHAN 32-bit FIFOs and
// emits a framed 64-bit DAQ packet (two headers, paired data words, trailer).
module multi_chan_data_transfer #(
  parameter int NUM_CHAN = 4,
  parameter int TRIG_W   = 24,
  parameter int CNT_W    = 16,
  localparam int CHAN_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CHAN*32-1:0]   fifo_data,
  input  logic [NUM_CHAN-1:0]      fifo_valid,
  input  logic [NUM_CHAN-1:0]      fifo_last,
  output logic [NUM_CHAN-1:0]      fifo_ready,
  output logic [63:0]              daq_data,
  output logic                     daq_valid,
  output logic                     daq_header,
  output logic                     daq_trailer,
  input  logic                     daq_ready,
  output logic [CHAN_W-1:0]        pkt_chan
);

  // DAQ side: a word transfers when daq_valid && daq_ready; daq_data is held while stalled.
  // FIFO side: a word pops when fifo_valid[sel] && fifo_ready[sel].
  typedef enum logic [2:0] {
    IDLE, HEADER1, HEADER2, FETCH_HI, FETCH_LO, SEND_DATA, SEND_LAST, TRAILER
  } state_t;

  state_t              state_q, state_d;
  logic [63:0]         daq_data_q, daq_data_d;
  logic [TRIG_W-1:0]   trig_num_q, trig_num_d, trig_inc;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d, cnt_inc;
  logic [CHAN_W-1:0]   sel_q, sel_d, last_sel_q, last_sel_d, rr_sel;
  logic [31:0]         sel_word;
  logic                sel_valid, sel_last;

  assign trig_inc = trig_num_q + 1'b1;
  assign cnt_inc  = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;

  // Second pass overrides the first, so channels above last_sel win over wrapped ones.
  always_comb begin
    rr_sel = '0;
    for (int c = NUM_CHAN - 1; c >= 0; c--)
      if (fifo_valid[c] && c <= int'(last_sel_q)) rr_sel = CHAN_W'(c);
    for (int c = NUM_CHAN - 1; c >= 0; c--)
      if (fifo_valid[c] && c > int'(last_sel_q)) rr_sel = CHAN_W'(c);
  end

  always_comb begin
    sel_word  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (int'(sel_q) == c) begin
        sel_word  = fifo_data[32*c +: 32];
        sel_valid = fifo_valid[c];
        sel_last  = fifo_last[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      daq_data_q <= '0;
      trig_num_q <= '0;
      word_cnt_q <= '0;
      sel_q      <= '0;
      last_sel_q <= CHAN_W'(NUM_CHAN - 1);
    end else begin
      state_q    <= state_d;
      daq_data_q <= daq_data_d;
      trig_num_q <= trig_num_d;
      word_cnt_q <= word_cnt_d;
      sel_q      <= sel_d;
      last_sel_q <= last_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    daq_data_d = daq_data_q;
    trig_num_d = trig_num_q;
    word_cnt_d = word_cnt_q;
    sel_d      = sel_q;
    last_sel_d = last_sel_q;
    case (state_q)
      IDLE: if (|fifo_valid) begin
        sel_d      = rr_sel;
        trig_num_d = trig_inc;
        daq_data_d = {5'b0, 3'(rr_sel), 24'(trig_inc), 32'h0000_0008};
        state_d    = HEADER1;
      end
      HEADER1: if (daq_ready) begin
        daq_data_d = 64'h0000_0000_0000_FFFF;
        state_d    = HEADER2;
      end
      HEADER2: if (daq_ready) begin
        daq_data_d = '0;
        state_d    = FETCH_HI;
      end
      FETCH_HI: if (sel_valid) begin
        daq_data_d = {sel_word, 32'h0};
        state_d    = sel_last ? SEND_LAST : FETCH_LO;
      end
      FETCH_LO: if (sel_valid) begin
        daq_data_d = {daq_data_q[63:32], sel_word};
        state_d    = sel_last ? SEND_LAST : SEND_DATA;
      end
      SEND_DATA: if (daq_ready) begin
        word_cnt_d = cnt_inc;
        daq_data_d = '0;
        state_d    = FETCH_HI;
      end
      SEND_LAST: if (daq_ready) begin
        daq_data_d = {32'(cnt_inc), trig_num_q[7:0], 24'h00_0008};
        state_d    = TRAILER;
      end
      TRAILER: if (daq_ready) begin
        daq_data_d = '0;
        word_cnt_d = '0;
        last_sel_d = sel_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    daq_valid   = 1'b0;
    daq_header  = 1'b0;
    daq_trailer = 1'b0;
    fifo_ready  = '0;
    case (state_q)
      HEADER1:   begin daq_valid = 1'b1; daq_header = 1'b1; end
      HEADER2:   daq_valid = 1'b1;
      SEND_DATA: daq_valid = 1'b1;
      SEND_LAST: daq_valid = 1'b1;
      TRAILER:   begin daq_valid = 1'b1; daq_trailer = 1'b1; end
      FETCH_HI, FETCH_LO:
        for (int c = 0; c < NUM_CHAN; c++) fifo_ready[c] = (int'(sel_q) == c);
      default: ;
    endcase
    pkt_chan = (state_q == IDLE) ? '0 : sel_q;
  end

  assign daq_data = daq_data_q;

endmodule

// File: tb/tb_multi_chan_data_transfer.sv
// Bench for multi_chan_data_transfer: per-channel event sources, random DAQ stalls and an
// event-level packet model that predicts every accepted DAQ word.
module tb_multi_chan_data_transfer;
  localparam int NUM_CHAN = 4;
  localparam int TRIG_W   = 8;
  localparam int CNT_W    = 4;
  localparam int CHAN_W   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_CHAN*32-1:0] fifo_data;
  logic [NUM_CHAN-1:0]    fifo_valid, fifo_last, fifo_ready;
  logic [63:0]            daq_data;
  logic                   daq_valid, daq_header, daq_trailer, daq_ready;
  logic [CHAN_W-1:0]      pkt_chan;

  multi_chan_data_transfer #(.NUM_CHAN(NUM_CHAN), .TRIG_W(TRIG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_last(fifo_last), .fifo_ready(fifo_ready), .daq_data(daq_data),
    .daq_valid(daq_valid), .daq_header(daq_header), .daq_trailer(daq_trailer),
    .daq_ready(daq_ready), .pkt_chan(pkt_chan)
  );

  always #5 clk = ~clk;

  // Expected word: {chan[2:0], header, trailer, data[63:0]}
  logic [68:0] exp_q[$];
  logic [32:0] src_q[NUM_CHAN][$];
  logic [32:0] mdl_q[NUM_CHAN][$];
  int          n_pass = 0, n_total = 0;
  int          m_trig = 0, m_last = NUM_CHAN - 1;
  int          pend_pop = -1, pop_cnt = 0;
  bit          gaps_en = 0, stall_en = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data;
  logic [68:0] mon_e;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int src_left();
    int s = 0;
    for (int c = 0; c < NUM_CHAN; c++) s += src_q[c].size();
    return s;
  endfunction

  // Source: presents queue heads, pops on the edge that the DUT pops on.
  initial begin : source
    fifo_valid = '0; fifo_last = '0; fifo_data = '0; daq_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (pend_pop >= 0 && src_q[pend_pop].size() > 0) begin
        void'(src_q[pend_pop].pop_front());
        pop_cnt++;
      end
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (src_q[c].size() > 0 && !(gaps_en && $urandom_range(0, 2) == 0)) begin
          fifo_valid[c]          = 1'b1;
          fifo_data[32*c +: 32]  = src_q[c][0][31:0];
          fifo_last[c]           = src_q[c][0][32];
        end else begin
          fifo_valid[c]          = 1'b0;
          fifo_data[32*c +: 32]  = $urandom;
          fifo_last[c]           = 1'($urandom_range(0, 1));
        end
      end
      daq_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      pend_pop = -1;
      if (!rst)
        for (int c = 0; c < NUM_CHAN; c++)
          if (fifo_valid[c] && fifo_ready[c]) pend_pop = c;
    end
  end

  // Monitor: scoreboard on every DAQ handshake plus hold-while-stalled check.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 0;
      else begin
        if (prev_stall) check("stall_hold", 69'({daq_valid, daq_data}), 69'({1'b1, prev_data}));
        if (daq_valid && daq_ready) begin
          check("unexpected_word", 69'(exp_q.size() != 0), 69'(1));
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("daq_word", {3'(pkt_chan), daq_header, daq_trailer, daq_data}, mon_e);
          end
        end
        prev_stall = daq_valid && !daq_ready;
        prev_data  = daq_data;
      end
    end
  end

  task automatic add_word(input int c, input logic [31:0] w, input bit last);
    src_q[c].push_back({last, w});
    mdl_q[c].push_back({last, w});
  endtask

  task automatic add_event(input int c, input int len);
    for (int i = 0; i < len; i++) add_word(c, $urandom, i == len - 1);
  endtask

  // Event-level model: round-robin over pending events, frame each into DAQ words.
  task automatic model_run();
    int c, n, cnt;
    logic [31:0] w[$];
    logic [32:0] e;
    logic [31:0] lo;
    forever begin
      c = -1;
      for (int k = 1; k <= NUM_CHAN; k++)
        if (c < 0 && mdl_q[(m_last + k) % NUM_CHAN].size() > 0) c = (m_last + k) % NUM_CHAN;
      if (c < 0) break;
      w.delete();
      do begin
        e = mdl_q[c].pop_front();
        w.push_back(e[31:0]);
      end while (!e[32]);
      m_trig = (m_trig + 1) % (1 << TRIG_W);
      exp_q.push_back({3'(c), 2'b10, 5'b0, 3'(c), 24'(m_trig), 32'h8});
      exp_q.push_back({3'(c), 2'b00, 64'hFFFF});
      n = (w.size() + 1) / 2;
      for (int k = 0; k < n; k++) begin
        lo = (2*k + 1 < w.size()) ? w[2*k+1] : 32'h0;
        exp_q.push_back({3'(c), 2'b00, w[2*k], lo});
      end
      cnt = (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
      exp_q.push_back({3'(c), 2'b01, 32'(cnt), 8'(m_trig), 24'h000008});
      m_last = c;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && (exp_q.size() != 0 || src_left() != 0)) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_drain"}, 69'(exp_q.size() + src_left()), 69'(0));
    check({tag, "_idle"}, 69'(daq_valid), 69'(0));
  endtask

  // Called at posedge+2; checks outputs the cycle after the first reset edge.
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    for (int c = 0; c < NUM_CHAN; c++) begin src_q[c].delete(); mdl_q[c].delete(); end
    m_trig = 0;
    m_last = NUM_CHAN - 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid",   69'(daq_valid),   69'(0));
    check("rst_header",  69'(daq_header),  69'(0));
    check("rst_trailer", 69'(daq_trailer), 69'(0));
    check("rst_data",    69'(daq_data),    69'(0));
    check("rst_ready",   69'(fifo_ready),  69'(0));
    check("rst_chan",    69'(pkt_chan),    69'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic directed_abcd(input logic [31:0] a, b, c, d);
    add_word(0, a, 0); add_word(0, b, 0); add_word(0, c, 0); add_word(0, d, 1);
    mdl_q[0].delete();
    exp_q.push_back({3'd0, 2'b10, 64'h0000_0001_0000_0008});
    exp_q.push_back({3'd0, 2'b00, 64'h0000_0000_0000_FFFF});
    exp_q.push_back({3'd0, 2'b00, a, b});
    exp_q.push_back({3'd0, 2'b00, c, d});
    exp_q.push_back({3'd0, 2'b01, 32'h2, 8'h01, 24'h000008});
    m_trig = 1;
    m_last = 0;
  endtask

  initial begin : main
    logic [31:0] wa, wb, wc, wd;
    int p0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    do_reset();

    // Four-word event on channel 0, DAQ always ready
    wa = $urandom; wb = $urandom; wc = $urandom; wd = $urandom;
    directed_abcd(wa, wb, wc, wd);
    drain("abcd", 200);

    // Single-word event on channel 2 gets padded
    add_event(2, 1);
    model_run();
    drain("single", 200);

    // Channels 1 and 3 both pending: alternate 1,3,1,3 from a fresh reset
    do_reset();
    add_event(1, 1); add_event(1, 1); add_event(3, 1); add_event(3, 1);
    model_run();
    drain("alt", 400);

    // Same four-word stream under random DAQ stalls and FIFO gaps
    do_reset();
    stall_en = 1; gaps_en = 1;
    directed_abcd(wa, wb, wc, wd);
    drain("abcd_stall", 400);
    for (int k = 0; k < 6; k++) begin
      add_event($urandom_range(0, NUM_CHAN - 1), $urandom_range(1, 9));
      model_run();
      drain("rand_single", 600);
    end
    gaps_en = 0;
    for (int k = 0; k < 12; k++) add_event($urandom_range(0, NUM_CHAN - 1), $urandom_range(1, 6));
    model_run();
    drain("rand_multi", 3000);

    // Reset while in FETCH_LO, then channel 0 must win with trig 1
    stall_en = 0;
    do_reset();
    add_event(2, 6);
    model_run();
    p0 = pop_cnt;
    for (int n = 0; n < 50 && pop_cnt != p0 + 1; n++) begin @(posedge clk); #2; end
    check("reach_fetch_lo", 69'(pop_cnt), 69'(p0 + 1));
    do_reset();
    add_event(2, 3); add_event(0, 2);
    model_run();
    drain("post_rst", 400);

    // Trigger wrap over 256 events, then word-count saturation
    do_reset();
    stall_en = 1;
    for (int k = 0; k < 256; k++) add_event($urandom_range(0, NUM_CHAN - 1), 1);
    model_run();
    drain("trig_wrap", 8000);
    stall_en = 0;
    add_event(3, 40);
    model_run();
    drain("cnt_sat", 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_chan_data_transfer.md
MULTI_CHAN_DATA_TRANSFER -- requirements
Module: multi_chan_data_transfer

Interface
REQ-001 Parameter NUM_CHAN, default 4, number of input FIFO channels; legal range 1..8.
REQ-002 Parameter TRIG_W, default 24, trigger counter width; legal range 8..24.
REQ-003 Parameter CNT_W, default 16, packet data-word counter width; legal range 4..32.
REQ-004 Local CHAN_W = max(1, clog2(NUM_CHAN)).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 fifo_data  input  NUM_CHAN*32  channel c word at bits [32c+31:32c].
REQ-008 fifo_valid  input  NUM_CHAN  per-channel word valid.
REQ-009 fifo_last  input  NUM_CHAN  per-channel last word of event; qualified by fifo_valid.
REQ-010 fifo_ready  output  NUM_CHAN  per-channel pop strobe.
REQ-011 daq_data  output  64  registered DAQ word.
REQ-012 daq_valid  output  1  daq_data valid.
REQ-013 daq_header  output  1  first header word flag.
REQ-014 daq_trailer  output  1  trailer word flag.
REQ-015 daq_ready  input  1  DAQ accepts word when daq_valid && daq_ready.
REQ-016 pkt_chan  output  CHAN_W  channel of current packet; 0 in IDLE.

Function
REQ-017 States: IDLE, HEADER1, HEADER2, FETCH_HI, FETCH_LO, SEND_DATA, SEND_LAST, TRAILER.
REQ-018 All outputs registered or decoded from state only; no combinational path from any input to any output.
REQ-019 daq_valid high exactly in HEADER1, HEADER2, SEND_DATA, SEND_LAST, TRAILER; daq_header only in HEADER1; daq_trailer only in TRAILER.
REQ-020 fifo_ready[sel] high exactly in FETCH_HI and FETCH_LO; all other bits 0; pop occurs when fifo_valid[sel] && fifo_ready[sel].
REQ-021 daq_data and daq_valid held stable while daq_valid && !daq_ready; state advances only on handshake.
REQ-022 IDLE: when any fifo_valid bit set, sel = first set channel searching upward from (last_sel+1) mod NUM_CHAN with wrap (round-robin); trig_num <= trig_num+1 mod 2^TRIG_W; daq_data <= {5'b0, sel zero-extended to 3 bits, new trig_num zero-extended to 24 bits, 32'h00000008}; go HEADER1.
REQ-023 HEADER1 handshake: daq_data <= 64'h000000000000FFFF; go HEADER2.
REQ-024 HEADER2 handshake: daq_data <= 0; go FETCH_HI.
REQ-025 FETCH_HI pop: daq_data <= {word, 32'h0}; fifo_last -> SEND_LAST (odd word, low half zero pad), else FETCH_LO.
REQ-026 FETCH_LO pop: daq_data[31:0] <= word, upper half kept; fifo_last -> SEND_LAST, else SEND_DATA.
REQ-027 Fetch states wait indefinitely while fifo_valid[sel] low; other channels' valid/last ignored for whole packet.
REQ-028 SEND_DATA handshake: word_cnt++; daq_data <= 0; go FETCH_HI.
REQ-029 SEND_LAST handshake: daq_data <= {word_cnt+1 zero-extended to 32 bits, trig_num[7:0], 24'h000008}; go TRAILER.
REQ-030 word_cnt counts accepted 64-bit data words per packet, saturates at all-ones (no wrap), including the +1 in REQ-029.
REQ-031 TRAILER handshake: daq_data <= 0; word_cnt <= 0; last_sel <= sel; go IDLE.
REQ-032 Minimum packet: 4 DAQ words (HEADER1, HEADER2, one data, TRAILER); one-word event padded.
REQ-033 trig_num wraps 2^TRIG_W-1 -> 0 with no other side effect.
REQ-034 pkt_chan = sel in all non-IDLE states.

Reset
REQ-035 rst (sampled at clk edge) forces IDLE, daq_data=0, trig_num=0, word_cnt=0, sel=0, last_sel=NUM_CHAN-1 (channel 0 wins first); all outputs 0 next cycle.
REQ-036 rst mid-packet abandons the packet without trailer; no FIFO word popped in the reset cycle.

Verification
REQ-037 Ch0 event of 4 words A,B,C,D, daq_ready=1 -> H1 {8'h00,24'h000001,32'h8}, H2 64'hFFFF, {A,B}, {C,D}, trailer {32'h2, 8'h01, 24'h000008}.
REQ-038 Ch2 single word E (NUM_CHAN=4) -> H1 chan field 2, data {E,32'h0}, trailer count 1.
REQ-039 Channels 1 and 3 valid continuously, one-word events -> packets alternate 1,3,1,3; trig_num 1..4 in headers.
REQ-040 daq_ready toggled randomly (50%) mid-packet -> daq_data stable when stalled; output stream identical to REQ-037.
REQ-041 TRIG_W=8, 256 events -> 256th header trig field 0x00; CNT_W=4, 20-word-pair event -> trailer count 15.
REQ-042 rst asserted in FETCH_LO -> next cycle IDLE, all outputs 0; next event header trig 1, channel 0 preferred.
